// File: rtl/avm_port_arbiter.sv
// Shares one Avalon-MM master port between a read requester and a write requester.
// Round-robin between the two; a write never issues while pipelined reads are still outstanding.
module avm_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_grant,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              protocol_err
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RD_CMD, WR_CMD, DRAIN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] outstanding, outstanding_n;
  logic             last_rd, last_rd_n;
  logic             rd_accept, wr_accept, rd_ret, rd_elig, ld_rd, ld_wr;

  // The strobes come straight from the state register, so a grant is the
  // registered strobe qualified by the slave's accept in the same cycle.
  assign rd_accept = avm_read & ~avm_waitrequest;
  assign wr_accept = avm_write & ~avm_waitrequest;
  assign rd_grant  = rd_accept;
  assign wr_grant  = wr_accept;
  assign rd_ret    = avm_readdatavalid & (outstanding != '0);
  assign rd_elig   = rd_req & (outstanding < MAX_CNT);

  always_comb begin
    outstanding_n = outstanding;
    if (rd_accept & ~rd_ret)      outstanding_n = outstanding + 1'b1;
    else if (~rd_accept & rd_ret) outstanding_n = outstanding - 1'b1;
  end

  always_comb begin
    state_n   = state;
    last_rd_n = last_rd;
    case (state)
      IDLE: begin
        // On a tie the side that did not win last time goes first.
        if (rd_elig && (!wr_req || !last_rd)) state_n = RD_CMD;
        else if (wr_req)                      state_n = (outstanding == '0) ? WR_CMD : DRAIN;
      end
      DRAIN: begin
        if (outstanding_n == '0) state_n = WR_CMD;
      end
      RD_CMD: begin
        if (!avm_waitrequest) begin
          state_n   = IDLE;
          last_rd_n = 1'b1;
        end
      end
      WR_CMD: begin
        if (!avm_waitrequest) begin
          state_n   = IDLE;
          last_rd_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ld_rd = (state_n == RD_CMD) && (state != RD_CMD);
  assign ld_wr = (state_n == WR_CMD) && (state != WR_CMD);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      outstanding   <= '0;
      last_rd       <= 1'b0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      busy          <= 1'b0;
      protocol_err  <= 1'b0;
    end else begin
      state       <= state_n;
      outstanding <= outstanding_n;
      last_rd     <= last_rd_n;
      avm_read    <= (state_n == RD_CMD);
      avm_write   <= (state_n == WR_CMD);
      if (ld_rd) avm_address <= rd_addr;
      if (ld_wr) begin
        avm_address   <= wr_addr;
        avm_writedata <= wr_data;
      end
      rd_valid <= rd_ret;
      if (rd_ret) rd_data <= avm_readdata;
      busy <= (state_n != IDLE) || (outstanding_n != '0);
      // Data returned with nothing in flight is dropped and flagged until reset.
      if (avm_readdatavalid && (outstanding == '0)) protocol_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_avm_port_arbiter.sv
// Bench for avm_port_arbiter: directed vector table, hand-written corner sequences, and a
// randomized phase checked against a memory/ordering reference model plus a slave-side monitor.
`timescale 1ns/1ps
module tb_avm_port_arbiter;
  localparam int AW = 32, DW = 32, MAXO = 4;
  localparam int N_RD = 60, N_WR = 40;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_grant, rd_valid, wr_grant, avm_read, avm_write, busy, protocol_err;
  logic [DW-1:0] rd_data, avm_writedata;
  logic [AW-1:0] avm_address;
  logic          avm_waitrequest, avm_readdatavalid;
  logic [DW-1:0] avm_readdata;

  avm_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .n_rst(n_rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wr_grant),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] d; } ret_t;
  typedef struct { bit is_wr; logic [31:0] addr; logic [31:0] data; int stall; int lat; int exp_gc; } vec_t;

  int checks = 0, errors = 0;
  int cyc = 0, stall_left = 0, cfg_stall = 0, cfg_lat = 1;
  int rdv_cnt = 0, rd_issued = 0, rd_done = 0, wr_issued = 0, wr_done = 0;
  bit slave_en = 1'b1, rnd_mode = 1'b0, chk_q = 1'b0, in_cmd = 1'b0;
  logic [31:0] cmd_addr, cmd_data, last_rdata;
  ret_t ret_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] smem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  function automatic logic [31:0] smem_rd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [31:0] mmem_rd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // Slave model: stalls each command, returns read data in order after a latency.
  task automatic slave_step();
    ret_t r;
    cyc++;
    if (!slave_en) return;
    if (avm_read || avm_write) begin
      if (!in_cmd) begin
        in_cmd     = 1'b1;
        stall_left = rnd_mode ? int'($urandom_range(0, 2)) : cfg_stall;
        cmd_addr   = avm_address;
        cmd_data   = avm_writedata;
      end else chk("cmd_stable", {avm_address, avm_writedata}, {cmd_addr, cmd_data});
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
        in_cmd = 1'b0;
        if (avm_read) begin
          r.due = cyc + (rnd_mode ? int'($urandom_range(1, 4)) : cfg_lat);
          r.d   = smem_rd(avm_address);
          ret_q.push_back(r);
          chk("max_outstanding", ret_q.size() <= MAXO, 1);
        end else begin
          chk("wr_after_drain", ret_q.size(), 0);
          smem[avm_address] = avm_writedata;
        end
      end
    end else avm_waitrequest = 1'b0;
    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = ret_q[0].d;
      void'(ret_q.pop_front());
    end else avm_readdatavalid = 1'b0;
  endtask

  // Random requesters; expected read data comes from a memory model updated at write grants.
  task automatic gen_step();
    if (rd_req && rd_grant) begin
      chk("rnd_rd_addr", avm_address, rd_addr);
      exp_q.push_back(mmem_rd(rd_addr));
      rd_req = 1'b0;
      rd_done++;
    end else if (!rd_req && rd_issued < N_RD && $urandom_range(0, 3) != 0) begin
      rd_addr = $urandom_range(0, 7) * 4;
      rd_req  = 1'b1;
      rd_issued++;
    end
    if (wr_req && wr_grant) begin
      chk("rnd_wr_cmd", {avm_address, avm_writedata}, {wr_addr, wr_data});
      mmem[wr_addr] = wr_data;
      wr_req = 1'b0;
      wr_done++;
    end else if (!wr_req && wr_issued < N_WR && $urandom_range(0, 3) == 0) begin
      wr_addr = $urandom_range(0, 7) * 4;
      wr_data = $urandom;
      wr_req  = 1'b1;
      wr_issued++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    slave_step();
    #1;
    if (rd_valid) begin
      rdv_cnt++;
      last_rdata = rd_data;
      if (chk_q) begin
        chk("rd_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
    if (rnd_mode) gen_step();
  endtask

  task automatic reset_dut();
    n_rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    ret_q.delete(); in_cmd = 1'b0;
    tick(); tick();
    n_rst = 1'b1;
    tick();
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int gc, vc, sc;
    logic [31:0] got;
    gc = -1; vc = -1; sc = 0; got = '0;
    cfg_stall = v.stall; cfg_lat = v.lat;
    if (v.is_wr) begin wr_req = 1'b1; wr_addr = v.addr; wr_data = v.data; end
    else begin rd_req = 1'b1; rd_addr = v.addr; end
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (avm_read || avm_write) sc++;
      if (gc < 0 && (v.is_wr ? wr_grant : rd_grant)) begin
        gc = c;
        chk($sformatf("vec%0d_addr", i), avm_address, v.addr);
        if (v.is_wr) chk($sformatf("vec%0d_wdata", i), avm_writedata, v.data);
        rd_req = 1'b0; wr_req = 1'b0;
      end
      if (rd_valid && vc < 0) begin vc = c; got = rd_data; end
    end
    rd_req = 1'b0; wr_req = 1'b0;
    chk($sformatf("vec%0d_grant_cycle", i), gc, v.exp_gc);
    chk($sformatf("vec%0d_strobe_cycles", i), sc, v.stall + 1);
    if (!v.is_wr) begin
      chk($sformatf("vec%0d_valid_cycle", i), vc, v.exp_gc + v.lat + 1);
      chk($sformatf("vec%0d_rdata", i), got, v.data);
    end
    chk($sformatf("vec%0d_busy_end", i), busy, 0);
  endtask

  task automatic txn(input bit do_rd, input bit do_wr, output int rg, output int wg);
    rg = -1; wg = -1;
    rd_req = do_rd; rd_addr = 32'h40; wr_req = do_wr; wr_addr = 32'h44; wr_data = 32'h1234;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (rd_req && rd_grant) begin rg = c; rd_req = 1'b0; end
      if (wr_req && wr_grant) begin wg = c; wr_req = 1'b0; end
    end
  endtask

  task automatic rd_try(input logic [31:0] a, input int bound, output bit g);
    g = 1'b0; rd_req = 1'b1; rd_addr = a;
    for (int c = 0; c < bound; c++) begin
      tick();
      if (rd_grant) begin g = 1'b1; rd_req = 1'b0; break; end
    end
  endtask

  initial begin
    int rg, wg, gcnt;
    bit g, seen;
    vecs[0] = '{1'b1, 32'h100, 32'h0000_ABCD, 0, 1, 1};
    vecs[1] = '{1'b0, 32'h100, 32'h0000_ABCD, 0, 3, 1};
    vecs[2] = '{1'b1, 32'h200, 32'h0000_0055, 3, 1, 4};
    vecs[3] = '{1'b0, 32'h200, 32'h0000_0055, 2, 1, 3};
    vecs[4] = '{1'b0, 32'h300, 32'h5A5A_0300, 1, 4, 2};
    vecs[5] = '{1'b1, 32'h300, 32'hFFFF_FFFF, 1, 1, 2};
    vecs[6] = '{1'b0, 32'h300, 32'hFFFF_FFFF, 0, 2, 1};

    n_rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    tick();
    chk("reset_ctl", {rd_grant, rd_valid, wr_grant, avm_read, avm_write, busy, protocol_err}, 0);
    chk("reset_addr_data", {avm_address, avm_writedata}, 0);
    n_rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Ties: read wins first, write drains behind it; alternation after a lone read.
    reset_dut(); cfg_stall = 0; cfg_lat = 2;
    txn(1, 1, rg, wg); chk("tie1_rd_cycle", rg, 1); chk("tie1_wr_cycle", wg, 4);
    txn(1, 1, rg, wg); chk("tie2_rd_cycle", rg, 1); chk("tie2_wr_cycle", wg, 4);
    txn(1, 0, rg, wg); chk("lone_rd_cycle", rg, 1);
    txn(1, 1, rg, wg); chk("tie3_wr_cycle", wg, 1); chk("tie3_rd_cycle", rg, 3);

    // Outstanding limit with no returns, then return and accept in the same cycle.
    reset_dut(); slave_en = 1'b0; rdv_cnt = 0; gcnt = 0;
    for (int i = 0; i < 5; i++) begin rd_try(32'(i * 4), 6, g); gcnt += int'(g); end
    chk("t4_grants_at_limit", gcnt, MAXO);
    avm_readdatavalid = 1'b1; avm_readdata = 32'h1111;
    tick();
    avm_readdatavalid = 1'b0;
    g = 1'b0;
    for (int c = 0; c < 6 && !g; c++) begin
      tick();
      if (rd_grant) begin g = 1'b1; rd_req = 1'b0; avm_readdatavalid = 1'b1; avm_readdata = 32'h2222; end
    end
    tick();
    avm_readdatavalid = 1'b0;
    chk("t4_held_read_granted", g, 1);
    rd_try(32'h50, 6, g); chk("t4_one_slot_free", g, 1);
    rd_try(32'h54, 6, g); chk("t4_full_again", g, 0);
    chk("t4_valid_count", rdv_cnt, 2);
    chk("t4_last_rdata", last_rdata, 32'h2222);

    // Stray readdatavalid.
    reset_dut(); rdv_cnt = 0;
    avm_readdatavalid = 1'b1; avm_readdata = 32'h3333;
    tick();
    avm_readdatavalid = 1'b0;
    chk("t5_err_set", protocol_err, 1);
    chk("t5_no_valid", rd_valid, 0);
    tick(); tick(); tick();
    chk("t5_err_sticky", protocol_err, 1);
    chk("t5_valid_count", rdv_cnt, 0);

    // Reset during a stalled read, with another read already outstanding.
    reset_dut();
    rd_try(32'h500, 4, g); chk("t6_first_read", g, 1);
    tick();
    avm_waitrequest = 1'b1; rd_req = 1'b1; rd_addr = 32'h600;
    tick(); tick();
    chk("t6_stalled", {avm_read, avm_address}, {1'b1, 32'h600});
    #1 n_rst = 1'b0;
    #1;
    chk("t6_rst_ctl", {rd_grant, rd_valid, wr_grant, avm_read, avm_write, busy, protocol_err}, 0);
    chk("t6_rst_addr_data", {avm_address, avm_writedata}, 0);
    chk("t6_rst_rdata", rd_data, 0);
    rd_req = 1'b0; avm_waitrequest = 1'b0;
    tick(); tick();
    n_rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin tick(); seen |= rd_grant | avm_read | busy; end
    chk("t6_idle_after", seen, 0);
    avm_readdatavalid = 1'b1;
    tick();
    avm_readdatavalid = 1'b0;
    tick();
    chk("t6_counter_cleared", protocol_err, 1);

    // Randomized traffic against the reference model.
    slave_en = 1'b1;
    reset_dut();
    exp_q.delete(); chk_q = 1'b1; rnd_mode = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      tick();
      if (rd_done == N_RD && wr_done == N_WR && exp_q.size() == 0) break;
    end
    rnd_mode = 1'b0;
    chk("rnd_reads_done", rd_done, N_RD);
    chk("rnd_writes_done", wr_done, N_WR);
    chk("rnd_all_returned", exp_q.size(), 0);
    tick(); tick();
    chk("rnd_busy_end", busy, 0);
    chk("rnd_no_protocol_err", protocol_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
